// File: rtl/replay_buffer_mc_if.sv
// Link-side bundle for the multi-channel replay buffer:
// enqueue, transmit, ack and nack groups plus channel status.
interface replay_buffer_mc_if #(
  parameter int NUM_CH       = 4,
  parameter int DEPTH        = 16,
  parameter int PACKET_WIDTH = 64
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SW = AW + 1;

  logic                    in_valid;
  logic [CW-1:0]           in_ch;
  logic [PACKET_WIDTH-1:0] in_packet;
  logic [NUM_CH-1:0]       in_ready;
  logic                    tx_valid;
  logic                    tx_ready;
  logic [CW-1:0]           tx_ch;
  logic [SW-1:0]           tx_seq;
  logic [PACKET_WIDTH-1:0] tx_packet;
  logic                    ack_valid;
  logic [CW-1:0]           ack_ch;
  logic [SW-1:0]           ack_seq;
  logic                    nack_valid;
  logic [CW-1:0]           nack_ch;
  logic [NUM_CH-1:0]       empty;

  modport master (
    output in_valid, in_ch, in_packet,
    output tx_ready,
    output ack_valid, ack_ch, ack_seq,
    output nack_valid, nack_ch,
    input  in_ready, tx_valid, tx_ch,
    input  tx_seq, tx_packet, empty
  );

  modport slave (
    input  in_valid, in_ch, in_packet,
    input  tx_ready,
    input  ack_valid, ack_ch, ack_seq,
    input  nack_valid, nack_ch,
    output in_ready, tx_valid, tx_ch,
    output tx_seq, tx_packet, empty
  );
endinterface

// File: rtl/replay_buffer_mc.sv
// Go-back-N replay buffer: per-channel circular stores with
// tail/cur/head pointers and a round-robin link arbiter.
module replay_buffer_mc #(
  parameter int NUM_CH       = 4,
  parameter int DEPTH        = 16,
  parameter int PACKET_WIDTH = 64
) (
  input logic              clk,
  input logic              nreset,
  replay_buffer_mc_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SW = AW + 1;
  localparam logic [SW-1:0] FULL = SW'(DEPTH);
  localparam logic [SW-1:0] ONE  = SW'(1);
  localparam logic [CW-1:0] LAST = CW'(NUM_CH - 1);

  logic [SW-1:0] head    [NUM_CH];
  logic [SW-1:0] cur     [NUM_CH];
  logic [SW-1:0] tail    [NUM_CH];
  logic [SW-1:0] cur_nx  [NUM_CH];
  logic [SW-1:0] tail_nx [NUM_CH];

  logic [PACKET_WIDTH-1:0] store [NUM_CH][DEPTH];

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] rdy;
  logic [NUM_CH-1:0] emp;
  logic [NUM_CH-1:0] wr_en;
  logic [CW-1:0]     rr;
  logic [CW-1:0]     lock_ch;
  logic [CW-1:0]     sel;
  logic [CW-1:0]     cand;
  logic              lock;
  logic              found;
  logic              tx_v;
  logic              fire;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      pending[c] = cur[c] != head[c];
      rdy[c]     = (head[c] - tail[c]) != FULL;
      emp[c]     = head[c] == tail[c];
      wr_en[c]   = bus.in_valid && rdy[c] &&
                   (bus.in_ch == CW'(c));
    end
  end

  // A stalled offer keeps its channel until the link takes it
  always_comb begin
    found = 1'b0;
    sel   = lock_ch;
    cand  = '0;
    if (!lock) begin
      for (int i = 1; i <= NUM_CH; i++) begin
        cand = CW'((int'(rr) + i) % NUM_CH);
        if (!found && pending[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
    end
  end

  assign tx_v = pending[sel];
  assign fire = tx_v && bus.tx_ready;

  assign bus.in_ready  = rdy;
  assign bus.empty     = emp;
  assign bus.tx_valid  = tx_v;
  assign bus.tx_ch     = sel;
  assign bus.tx_seq    = cur[sel];
  assign bus.tx_packet = store[sel][cur[sel][AW-1:0]];

  // Ack lands first so a same-cycle nack rewinds to the new tail
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      tail_nx[c] = tail[c];
      cur_nx[c]  = cur[c];
      if (bus.ack_valid && bus.ack_ch == CW'(c) &&
          (bus.ack_seq - tail[c]) < (cur[c] - tail[c]))
        tail_nx[c] = bus.ack_seq + ONE;
      if (bus.nack_valid && bus.nack_ch == CW'(c))
        cur_nx[c] = tail_nx[c];
      else if (fire && sel == CW'(c))
        cur_nx[c] = cur[c] + ONE;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        head[c] <= '0;
        cur[c]  <= '0;
        tail[c] <= '0;
      end
      rr      <= LAST;
      lock    <= 1'b0;
      lock_ch <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_en[c])
          head[c] <= head[c] + ONE;
        cur[c]  <= cur_nx[c];
        tail[c] <= tail_nx[c];
      end
      if (fire)
        rr <= sel;
      lock    <= tx_v && !bus.tx_ready;
      lock_ch <= sel;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en[c])
        store[c][head[c][AW-1:0]] <= bus.in_packet;
    end
  end
endmodule

// File: tb/tb_replay_buffer_mc.sv
// Bench for replay_buffer_mc: directed scenarios plus random
// traffic against a queue-level model of the replay windows.
module tb_replay_buffer_mc;
  localparam int NC = 4;
  localparam int DP = 16;
  localparam int PW = 64;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  replay_buffer_mc_if #(
    .NUM_CH(NC), .DEPTH(DP), .PACKET_WIDTH(PW)
  ) bus ();

  replay_buffer_mc #(
    .NUM_CH(NC), .DEPTH(DP), .PACKET_WIDTH(PW)
  ) dut (
    .clk(clk),
    .nreset(nreset),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // absolute (unwrapped) counters: oldest unacked, next to send
  // is tl+sn, next free is hd
  int hd [NC];
  int tl [NC];
  int sn [NC];
  logic [63:0] mm [NC][256];
  int rr_m;
  bit lk;
  int lk_ch;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(int c, int k);
    return {8'hA5, 8'(c), 16'h0, 32'(k)};
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      hd[c] = 0;
      tl[c] = 0;
      sn[c] = 0;
    end
    rr_m  = NC - 1;
    lk    = 1'b0;
    lk_ch = 0;
  endfunction

  function automatic void exp_tx(output bit v, output int ch);
    v  = 1'b0;
    ch = 0;
    if (lk) begin
      ch = lk_ch;
      v  = sn[ch] < hd[ch] - tl[ch];
    end else begin
      for (int i = 1; i <= NC; i++) begin
        int c;
        c = (rr_m + i) % NC;
        if (!v && sn[c] < hd[c] - tl[c]) begin
          v  = 1'b1;
          ch = c;
        end
      end
    end
  endfunction

  function automatic bit any_pend();
    bit p = 1'b0;
    for (int c = 0; c < NC; c++)
      if (sn[c] < hd[c] - tl[c]) p = 1'b1;
    return p;
  endfunction

  function automatic void model_step();
    bit v;
    int ch;
    int c;
    int d;
    bit room;
    exp_tx(v, ch);
    c = int'(bus.in_ch);
    room = (hd[c] - tl[c]) < DP;
    if (bus.ack_valid) begin
      c = int'(bus.ack_ch);
      d = (int'(bus.ack_seq) - tl[c]) & 31;
      if (d < sn[c]) begin
        tl[c] += d + 1;
        sn[c] -= d + 1;
      end
    end
    if (v && bus.tx_ready &&
        !(bus.nack_valid && int'(bus.nack_ch) == ch))
      sn[ch]++;
    if (bus.nack_valid)
      sn[int'(bus.nack_ch)] = 0;
    if (bus.in_valid && room) begin
      c = int'(bus.in_ch);
      mm[c][hd[c] % 256] = bus.in_packet;
      hd[c]++;
    end
    if (v && bus.tx_ready)
      rr_m = ch;
    lk    = v && !bus.tx_ready;
    lk_ch = ch;
  endfunction

  task automatic check_all();
    logic [3:0] er;
    logic [3:0] ee;
    bit v;
    int ch;
    int cp;
    er = 4'hF;
    ee = 4'hF;
    v  = 1'b0;
    ch = 0;
    if (nreset) begin
      for (int c = 0; c < NC; c++) begin
        er[c] = (hd[c] - tl[c]) < DP;
        ee[c] = hd[c] == tl[c];
      end
      exp_tx(v, ch);
    end
    chk("in_ready", 64'(bus.in_ready), 64'(er));
    chk("empty", 64'(bus.empty), 64'(ee));
    chk("tx_valid", 64'(bus.tx_valid), 64'(v));
    if (v) begin
      cp = tl[ch] + sn[ch];
      chk("tx_ch", 64'(bus.tx_ch), 64'(ch));
      chk("tx_seq", 64'(bus.tx_seq), 64'(cp % 32));
      chk("tx_packet", bus.tx_packet, mm[ch][cp % 256]);
    end
  endtask

  task automatic idle();
    bus.in_valid   = 1'b0;
    bus.in_ch      = '0;
    bus.in_packet  = '0;
    bus.tx_ready   = 1'b0;
    bus.ack_valid  = 1'b0;
    bus.ack_ch     = '0;
    bus.ack_seq    = '0;
    bus.nack_valid = 1'b0;
    bus.nack_ch    = '0;
  endtask

  task automatic tick();
    if (nreset) model_step();
    @(negedge clk);
    check_all();
    idle();
  endtask

  task automatic enq(input int c, input logic [63:0] p);
    bus.in_valid  = 1'b1;
    bus.in_ch     = 2'(c);
    bus.in_packet = p;
  endtask

  task automatic ack(input int c, input int s);
    bus.ack_valid = 1'b1;
    bus.ack_ch    = 2'(c);
    bus.ack_seq   = 5'(s);
  endtask

  task automatic drain();
    int n = 0;
    while (any_pend() && n < 64) begin
      bus.tx_ready = 1'b1;
      tick();
      n++;
    end
    if (n >= 64) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d cycles limit 64", n);
    end
    for (int c = 0; c < NC; c++) begin
      if (hd[c] != tl[c]) begin
        ack(c, (hd[c] - 1) % 32);
        tick();
      end
    end
  endtask

  initial begin
    idle();
    model_reset();
    @(negedge clk);
    check_all();
    chk("rst_in_ready", 64'(bus.in_ready), 64'hF);
    chk("rst_empty", 64'(bus.empty), 64'hF);
    chk("rst_tx_valid", 64'(bus.tx_valid), 64'h0);
    nreset = 1'b1;
    tick();

    // ch0: A, B, C stream out back to back
    for (int k = 0; k < 3; k++) begin
      enq(0, pk(0, k));
      bus.tx_ready = 1'b1;
      tick();
      chk("s1_seq", 64'(bus.tx_seq), 64'(k));
    end
    bus.tx_ready = 1'b1;
    tick();
    chk("s1_empty_hold", 64'(bus.empty[0]), 64'h0);
    ack(0, 1);
    tick();
    chk("s1_empty_part", 64'(bus.empty[0]), 64'h0);
    ack(0, 2);
    tick();
    chk("s1_empty", 64'(bus.empty[0]), 64'h1);

    // ch1: fill, drop 17th, free 5 slots
    for (int k = 0; k < 16; k++) begin
      enq(1, pk(1, k));
      bus.tx_ready = 1'b1;
      tick();
    end
    chk("s2_full", 64'(bus.in_ready[1]), 64'h0);
    enq(1, 64'hDEAD);
    bus.tx_ready = 1'b1;
    tick();
    chk("s2_drop", 64'(bus.in_ready[1]), 64'h0);
    chk("s2_drop_txv", 64'(bus.tx_valid), 64'h0);
    ack(1, 4);
    tick();
    chk("s2_ack_ready", 64'(bus.in_ready[1]), 64'h1);
    for (int k = 0; k < 5; k++) begin
      chk("s2_slot", 64'(bus.in_ready[1]), 64'h1);
      enq(1, pk(1, 16 + k));
      tick();
    end
    chk("s2_refull", 64'(bus.in_ready[1]), 64'h0);
    drain();

    // ch2: send 0..5, ack 1, nack -> replay 2..5
    for (int k = 0; k < 6; k++) begin
      enq(2, pk(2, k));
      bus.tx_ready = 1'b1;
      tick();
    end
    bus.tx_ready = 1'b1;
    tick();
    ack(2, 1);
    tick();
    bus.nack_valid = 1'b1;
    bus.nack_ch    = 2'd2;
    tick();
    for (int j = 2; j < 6; j++) begin
      chk("s3_replay_seq", 64'(bus.tx_seq), 64'(j));
      chk("s3_replay_pkt", bus.tx_packet, pk(2, j));
      bus.tx_ready = 1'b1;
      tick();
    end
    drain();

    // make ch3 the last grant, then load all channels
    enq(3, pk(3, 0));
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b1;
    tick();
    drain();
    for (int k = 0; k < 8; k++) begin
      enq(k % 4, pk(k % 4, 100 + k));
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      chk("s4_hold_ch", 64'(bus.tx_ch), 64'h0);
      chk("s4_hold_seq", 64'(bus.tx_seq), 64'd3);
      chk("s4_hold_pkt", bus.tx_packet, pk(0, 100));
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      chk("s4_rr", 64'(bus.tx_ch), 64'(i % 4));
      bus.tx_ready = 1'b1;
      tick();
    end
    drain();

    // ch0 seq 5..9: ack 6 + nack + tx_ready in one cycle
    for (int k = 0; k < 5; k++) begin
      enq(0, pk(0, 200 + k));
      bus.tx_ready = 1'b1;
      tick();
    end
    chk("s5_pre_seq", 64'(bus.tx_seq), 64'd9);
    ack(0, 6);
    bus.nack_valid = 1'b1;
    bus.nack_ch    = 2'd0;
    bus.tx_ready   = 1'b1;
    tick();
    chk("s5_seq", 64'(bus.tx_seq), 64'd7);
    chk("s5_pkt", bus.tx_packet, pk(0, 202));
    ack(0, 5);
    tick();
    chk("s5_stale_seq", 64'(bus.tx_seq), 64'd7);
    chk("s5_stale_empty", 64'(bus.empty[0]), 64'h0);
    drain();

    // ch3: 40 packets, seq starts at 3 and wraps
    for (int k = 0; k < 40; k++) begin
      enq(3, pk(3, 300 + k));
      tick();
      chk("s6_seq", 64'(bus.tx_seq), 64'((3 + k) % 32));
      chk("s6_pkt", bus.tx_packet, pk(3, 300 + k));
      bus.tx_ready = 1'b1;
      tick();
      ack(3, (3 + k) % 32);
      tick();
    end
    chk("s6_empty", 64'(bus.empty), 64'hF);

    // random traffic with a reset dropped in mid-stream
    for (int it = 0; it < 3000; it++) begin
      if (it == 1500) begin
        #2;
        nreset = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'hF);
        chk("mid_rst_empty", 64'(bus.empty), 64'hF);
        chk("mid_rst_tx_valid", 64'(bus.tx_valid), 64'h0);
        model_reset();
        @(negedge clk);
        check_all();
        nreset = 1'b1;
      end
      bus.in_valid  = $urandom_range(0, 9) < 7;
      bus.in_ch     = 2'($urandom_range(0, 3));
      bus.in_packet = {$urandom, $urandom};
      bus.tx_ready  = $urandom_range(0, 9) < 6;
      if ($urandom_range(0, 9) < 3) begin
        int c;
        c = int'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0)
          ack(c, int'($urandom_range(0, 31)));
        else
          ack(c, (tl[c] + int'($urandom_range(0, 20))) % 32);
      end
      if ($urandom_range(0, 19) == 0) begin
        bus.nack_valid = 1'b1;
        bus.nack_ch    = 2'($urandom_range(0, 3));
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/replay_buffer_mc.md
# replay_buffer_mc

Multi-channel go-back-N replay buffer for the mesh link layer. It sits between the packet sources of up to `NUM_CH` virtual channels and a single shared link transmitter. Each accepted packet is held in a per-channel circular store until the far end acknowledges it cumulatively by sequence number. A NACK rewinds that channel's transmit pointer to its oldest unacknowledged packet, and a round-robin arbiter selects which channel drives the link.

## Interface
- `NUM_CH`, 4, number of virtual channels (≥1)
- `DEPTH`, 16, entries per channel (power of two, ≥2)
- `PACKET_WIDTH`, 64, packet payload bits
- Derived: `AW = $clog2(DEPTH)`, `CW = max(1,$clog2(NUM_CH))`, `SW = AW+1` (sequence/pointer width)

Ports:
- `clk` in 1: single clock, rising edge
- `nreset` in 1: reset, asynchronous, active-low
- `in_valid` in 1: enqueue request
- `in_ch` in CW: target channel of enqueue
- `in_packet` in PACKET_WIDTH: payload
- `in_ready` out NUM_CH: bit c = channel c not full
- `tx_valid` out 1: packet offered to link
- `tx_ready` in 1: link accepts offered packet
- `tx_ch` out CW: channel of offered packet
- `tx_seq` out SW: sequence number of offered packet
- `tx_packet` out PACKET_WIDTH: offered payload
- `ack_valid` in 1: cumulative acknowledge
- `ack_ch` in CW: channel acknowledged
- `ack_seq` in SW: last sequence number received in order
- `nack_valid` in 1: replay request
- `nack_ch` in CW: channel to replay
- `empty` out NUM_CH: bit c = channel c holds no unacknowledged packet

## Operation
- Per channel, three SW-bit pointers `tail ≤ cur ≤ head`, all modulo 2^SW. Entry index is `ptr[AW-1:0]`; sequence number is the full pointer.
- Channel states are derived, not encoded: empty (`head==tail`); full (`head-tail==DEPTH`); pending (`cur!=head`).
- Enqueue: on `in_valid && in_ready[in_ch]`, store at `head[in_ch]`, then `head` increments. `in_valid` to a full channel is dropped with no state change.
- Transmit: the arbiter picks among pending channels round-robin, starting after the last granted channel (`rr`). `tx_seq = cur`, `tx_packet = store[ch][cur]`. On `tx_valid && tx_ready`: `cur` increments and `rr` is set to `tx_ch`.
- Hold rule: while `tx_valid && !tx_ready`, the selected channel is locked and `tx_ch`, `tx_seq` and `tx_packet` stay stable. The only exception is a NACK on the locked channel; it may change `tx_seq`, `tx_packet` or `tx_valid` in the next cycle.
- ACK window check: ACK is accepted iff `(ack_seq - tail) mod 2^SW < (cur - tail)`. When accepted, `tail` becomes `ack_seq+1` and entries are freed. Out-of-window ACKs (stale or duplicate) are ignored.
- NACK: sets `cur[nack_ch]` to `tail[nack_ch]` (after any same-cycle ACK is applied).
- Same-cycle priority on one channel:
  - ACK is applied first, then NACK uses the new tail.
  - NACK overrides the transmit increment.
  - Enqueue is independent of all three.
  - Events on different channels never interact.

## Timing
- Reset (async assert, sync release of state): all pointers 0, `rr` = NUM_CH-1, lock cleared.
- Outputs during reset: `in_ready` all 1, `empty` all 1, `tx_valid` 0. `tx_ch`, `tx_seq` and `tx_packet` are don't-care while `tx_valid=0`.
- Outputs are combinational from registered state only; there is no input-to-output combinational path.
- Enqueue → `tx_valid`: 1 cycle. The packet is offerable in the cycle after the write.
- ACK → `in_ready` rises: 1 cycle. NACK → replayed `tx_seq`: 1 cycle.
- Throughput:
  - One enqueue and one transmit per cycle.
  - A full channel accepts a new packet in the cycle after a freeing ACK.
  - Same-cycle enqueue into a slot being freed is not allowed; `in_ready` reflects registered state.
- Reset asserted mid-operation discards all stored packets and pointers immediately.

## Test plan
- Reset, then enqueue 3 packets on ch0 (A, B, C) with `tx_ready=1` → `tx_seq` 0, 1, 2 on consecutive cycles, starting 1 cycle after first write. `empty[0]` stays 0 until `ack_seq=2`, then goes to 1.
- Fill ch1 with 16 packets, no ACK → `in_ready[1]=0`, and a 17th `in_valid` is dropped. Then `ack_seq=4` → `in_ready[1]=1` next cycle, with 5 free slots.
- Send seq 0–5 on ch2, `ack_seq=1`, then NACK ch2 → next offered `tx_seq=2`, and 2, 3, 4, 5 are replayed in order.
- Channels 0–3 all pending with `tx_ready=1` → `tx_ch` sequence 0, 1, 2, 3, 0. Holding `tx_ready=0` for 5 cycles keeps `tx_ch`, `tx_seq` and `tx_packet` stable.
- Same cycle on ch0, with seq 0–3 sent: `ack_seq=1`, NACK, `tx_ready=1` → tail=2, cur=2, next `tx_seq=2`. A stale ACK `ack_seq=0` afterwards is ignored.
- Push 40 packets through ch3 with a per-packet ACK → `tx_seq` wraps 31→0, and all payloads arrive intact in order.
